seven_seg: RTL and testbench
============================

SEVEN_SEG -- requirements
Module: seven_seg

Interface
REQ-001 The block SHALL have parameter c_REFRESH_COUNT, default 100000, meaning clock cycles each digit is displayed (1 ms at 100 MHz); legal range 2 to 2^20.
REQ-002 The block SHALL have port i_Clk, input, 1 bit: single system clock (100 MHz nominal); all logic on its rising edge.
REQ-003 The block SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports i_Digit_1, i_Digit_2, i_Digit_3, i_Digit_4, input, 4 bits each: hex value 0x0-0xF shown on digits 1-4.
REQ-005 The block SHALL have port o_Anode, output, 4 bits: digit enables, active-low; bit n enables digit n+1.
REQ-006 The block SHALL have port o_Segment, output, 8 bits: cathodes, active-low; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.

Function
REQ-007 The block SHALL time-multiplex the four digits with a refresh counter of ceil(log2(c_REFRESH_COUNT)) bits counting 0 to c_REFRESH_COUNT-1 and wrapping to 0.
REQ-008 On wrap, the digit select SHALL advance 1->2->3->4->1; exactly one anode is low at any time after reset.
REQ-009 Anode patterns SHALL be: digit1=4'b1110, digit2=4'b1101, digit3=4'b1011, digit4=4'b0111.
REQ-010 o_Anode and o_Segment SHALL be registered outputs updated together on the same edge, so no glitch or mismatch occurs between an anode and its segment pattern.
REQ-011 o_Segment SHALL equal the decode of the selected digit's input sampled on the previous rising edge: latency of one clock.
REQ-012 Input changes mid-slot SHALL appear one clock later without waiting for the next slot.
REQ-013 Decode (hex->o_Segment) SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-014 The decimal point SHALL always be off (bit7=1).
REQ-015 Each digit SHALL be displayed for exactly c_REFRESH_COUNT cycles; full frame = 4*c_REFRESH_COUNT cycles.

Reset
REQ-016 While i_Rst_L=0, the block SHALL immediately (asynchronously) drive o_Anode=4'b1111 and o_Segment=8'hFF, clear the counter, and set the select to digit 1.
REQ-017 On the first rising edge after reset release, o_Anode SHALL become 4'b1110 with o_Segment=decode(i_Digit_1).
REQ-018 Reset asserted mid-slot SHALL abort the current slot, and scanning SHALL restart at digit 1 with a full-length slot.

Structure
REQ-019 Package seven_seg_pkg SHALL hold the 16-entry segment encoding constants, anode pattern constants, and the digit-select type (2-bit enum DIG1..DIG4).
REQ-020 The combinational decoder SHALL be a separate sub-module hex_to_7seg (4-bit in, 8-bit active-low out, dp=1), instantiated once on the muxed digit.
REQ-021 The top level SHALL contain only the counter, digit select, input mux, and output registers; it SHALL have no latches and no combinational paths from input to output.

Verification (bench with c_REFRESH_COUNT=4)
REQ-022 Hold i_Rst_L=0 -> o_Anode=1111, o_Segment=FF; release with digits 1,2,3,4 -> 1110/F9 for 4 clocks, 1101/A4 for 4, 1011/B0 for 4, 0111/99 for 4, then 1110 again.
REQ-023 All four digits increment 0..F and wrap to 0 every clock -> o_Segment follows the REQ-013 table with one-clock lag; value 0 after F is C0.
REQ-024 Assert reset while digit 3 is displayed -> outputs go 1111/FF without a clock edge; after release, digit 1 is shown for a full 4 cycles.
REQ-025 Set i_Digit_2 from 5 to E mid-slot while digit 2 is shown -> o_Segment changes 92->86 on the next edge; o_Anode is unchanged.
REQ-026 Scoreboard over 1000 frames -> exactly one anode low per cycle, bit7 always 1, each slot exactly 4 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment driver.
// Segment codes are active-low with the decimal point (bit 7) always off.
package seven_seg_pkg;

    typedef enum logic [1:0] {DIG1, DIG2, DIG3, DIG4} digit_sel_t;

    // Index n holds the code for hex value n (packed, so entry 0 is rightmost).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    localparam logic [3:0] ANODE_DIG1 = 4'b1110;
    localparam logic [3:0] ANODE_DIG2 = 4'b1101;
    localparam logic [3:0] ANODE_DIG3 = 4'b1011;
    localparam logic [3:0] ANODE_DIG4 = 4'b0111;

    function automatic logic [3:0] anode_for(input digit_sel_t sel);
        case (sel)
            DIG1:    return ANODE_DIG1;
            DIG2:    return ANODE_DIG2;
            DIG3:    return ANODE_DIG3;
            default: return ANODE_DIG4;
        endcase
    endfunction

    function automatic digit_sel_t next_sel(input digit_sel_t sel);
        case (sel)
            DIG1:    return DIG2;
            DIG2:    return DIG3;
            DIG3:    return DIG4;
            default: return DIG1;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex-to-segment decoder; active-low cathodes, decimal point off.
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] segment
);

    assign segment = SEG_TABLE[value];

endmodule

// File: rtl/seven_seg.sv
// Four-digit seven-segment scanner: a refresh counter steps the digit select, and
// the anode and segment outputs are registered together so they never disagree.
module seven_seg
    import seven_seg_pkg::*;
#(
    parameter int c_REFRESH_COUNT = 100000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [3:0] i_Digit_1,
    input  logic [3:0] i_Digit_2,
    input  logic [3:0] i_Digit_3,
    input  logic [3:0] i_Digit_4,
    output logic [3:0] o_Anode,
    output logic [7:0] o_Segment
);

    localparam int               CNT_W   = $clog2(c_REFRESH_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(c_REFRESH_COUNT - 1);

    logic [CNT_W-1:0] count;
    digit_sel_t       sel;
    logic [3:0]       digit;
    logic [7:0]       segment_next;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        digit = i_Digit_1;
        case (sel)
            DIG1:    digit = i_Digit_1;
            DIG2:    digit = i_Digit_2;
            DIG3:    digit = i_Digit_3;
            default: digit = i_Digit_4;
        endcase
    end

    hex_to_7seg u_decode (
        .value   (digit),
        .segment (segment_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
            sel   <= DIG1;
        end else if (count == CNT_MAX) begin
            count <= '0;
            sel   <= next_sel(sel);
        end else begin
            count <= count + 1'b1;
        end
    end

    // Outputs follow the select that is current on this edge, so a slot lasts exactly c_REFRESH_COUNT edges.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Anode   <= ANODE_OFF;
            o_Segment <= SEG_BLANK;
        end else begin
            o_Anode   <= anode_for(sel);
            o_Segment <= segment_next;
        end
    end

endmodule

// File: tb/tb_seven_seg.sv
// Directed bench for seven_seg with a 4-cycle refresh slot; outputs are sampled on
// the falling edge and inputs are driven right after that sample.
module tb_seven_seg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d1, d2, d3, d4;
    logic [3:0] anode;
    logic [7:0] seg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] an_tbl  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seven_seg #(.c_REFRESH_COUNT(4)) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Digit_1 (d1),
        .i_Digit_2 (d2),
        .i_Digit_3 (d3),
        .i_Digit_4 (d4),
        .o_Anode   (anode),
        .o_Segment (seg)
    );

    always #5 clk = ~clk;

    // Pulse reset; returns on the falling edge where reset was released.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (anode !== 4'b1111) $display("FAIL reset_anode got=%b exp=1111", anode); else n_pass++;
        n_checks++;
        if (seg !== 8'hFF) $display("FAIL reset_seg got=%h exp=FF", seg); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (anode !== 4'b1111 || seg !== 8'hFF)
            $display("FAIL reset_hold got=%b/%h exp=1111/FF", anode, seg);
        else n_pass++;
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            n_checks++;
            if (anode !== an_tbl[((k-1)/4)%4] || seg !== seg_tbl[((k-1)/4)%4 + 1])
                $display("FAIL scan_k%0d got=%b/%h exp=%b/%h", k, anode, seg,
                         an_tbl[((k-1)/4)%4], seg_tbl[((k-1)/4)%4 + 1]);
            else n_pass++;
        end
    endtask

    task automatic test_increment();
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                n_checks++;
                if (seg !== seg_tbl[(i-1)%16])
                    $display("FAIL incr_v%0d got=%h exp=%h", (i-1)%16, seg, seg_tbl[(i-1)%16]);
                else n_pass++;
            end
            if (i <= 16) begin
                d1 = 4'(i % 16); d2 = 4'(i % 16); d3 = 4'(i % 16); d4 = 4'(i % 16);
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        d1 = 4'h1; d2 = 4'h2; d3 = 4'h3; d4 = 4'h4;
        do_reset();
        repeat (9) @(negedge clk);
        n_checks++;
        if (anode !== 4'b1011) $display("FAIL mid_pre got=%b exp=1011", anode); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (anode !== 4'b1111 || seg !== 8'hFF)
            $display("FAIL mid_async got=%b/%h exp=1111/FF", anode, seg);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (k <= 4) begin
                if (anode !== 4'b1110 || seg !== 8'hF9)
                    $display("FAIL mid_restart_k%0d got=%b/%h exp=1110/F9", k, anode, seg);
                else n_pass++;
            end else begin
                if (anode !== 4'b1101 || seg !== 8'hA4)
                    $display("FAIL mid_next got=%b/%h exp=1101/A4", anode, seg);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_slot_change();
        d1 = 4'h1; d2 = 4'h5; d3 = 4'h3; d4 = 4'h4;
        do_reset();
        repeat (6) @(negedge clk);
        n_checks++;
        if (anode !== 4'b1101 || seg !== 8'h92)
            $display("FAIL change_before got=%b/%h exp=1101/92", anode, seg);
        else n_pass++;
        d2 = 4'hE;
        @(negedge clk);
        n_checks++;
        if (anode !== 4'b1101 || seg !== 8'h86)
            $display("FAIL change_after got=%b/%h exp=1101/86", anode, seg);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        logic [3:0] cur [4];
        int         slot;
        cur[0] = 4'h7; cur[1] = 4'hA; cur[2] = 4'h0; cur[3] = 4'hF;
        d1 = cur[0]; d2 = cur[1]; d3 = cur[2]; d4 = cur[3];
        do_reset();
        for (int k = 1; k <= 16000; k++) begin
            @(negedge clk);
            slot = ((k - 1) / 4) % 4;
            n_checks++;
            if (anode !== an_tbl[slot] || seg !== seg_tbl[cur[slot]])
                $display("FAIL sb_k%0d got=%b/%h exp=%b/%h", k, anode, seg, an_tbl[slot], seg_tbl[cur[slot]]);
            else n_pass++;
            n_checks++;
            if (seg[7] !== 1'b1) $display("FAIL sb_dp_k%0d got=%b exp=1", k, seg[7]); else n_pass++;
            for (int i = 0; i < 4; i++) cur[i] = 4'((k * 3 + i * 5 + k / 7) % 16);
            d1 = cur[0]; d2 = cur[1]; d3 = cur[2]; d4 = cur[3];
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d1 = '0; d2 = '0; d3 = '0; d4 = '0;
        test_reset();
        test_increment();
        test_reset_mid_slot();
        test_mid_slot_change();
        test_scoreboard();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
